ib_vnu_f1_array: RTL and testbench

IB_VNU_F1_ARRAY -- requirements
Module: ib_vnu_f1_array

---
 rtl/ib_vnu_f1_array.sv | 127 ++++++++++++
 tb/tb_ib_vnu_f1_array.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ib_vnu_f1_array.sv
// Parallel variable-node LUT lookup: LANE_NUM lanes share a multi-frame table, with a fixed
// 2-cycle read pipeline, per-frame load tracking and a PIPELINE_DEPTH delay line for c2v_2.
module ib_vnu_f1_array #(
   parameter int QUAN_SIZE       = 4,
   parameter int LANE_NUM        = 2,
   parameter int PIPELINE_DEPTH  = 3,
   parameter int MULTI_FRAME_NUM = 2,
   parameter int FRAME_W         = (MULTI_FRAME_NUM > 1) ? $clog2(MULTI_FRAME_NUM) : 1
) (
   input  logic                          read_clk,
   input  logic                          rstn,
   input  logic                          in_valid,
   input  logic [FRAME_W-1:0]            read_addr_offset,
   input  logic [LANE_NUM*QUAN_SIZE-1:0] t00,
   input  logic [LANE_NUM*QUAN_SIZE-1:0] c2v_1,
   input  logic [LANE_NUM*QUAN_SIZE-1:0] c2v_2,
   input  logic [LANE_NUM-1:0]           tran_en_in,
   input  logic                          lut_we,
   input  logic [FRAME_W-1:0]            lut_wr_frame,
   input  logic [2*QUAN_SIZE-1:0]        lut_wr_addr,
   input  logic [QUAN_SIZE-1:0]          lut_wr_data,
   input  logic                          lut_commit,
   output logic [LANE_NUM*QUAN_SIZE-1:0] v2c,
   output logic [LANE_NUM*QUAN_SIZE-1:0] dn_in,
   output logic [LANE_NUM*QUAN_SIZE-1:0] e_reg2,
   output logic [LANE_NUM-1:0]           tran_en_out,
   output logic [FRAME_W-1:0]            read_addr_offset_out,
   output logic                          out_valid,
   output logic                          lut_miss,
   output logic [MULTI_FRAME_NUM-1:0]    frame_loaded
);

   localparam int ADDR_W = FRAME_W + 2*QUAN_SIZE;
   localparam int DEPTH  = 1 << ADDR_W;
   localparam int BUS_W  = LANE_NUM*QUAN_SIZE;

   // Handshake: in_valid qualifies one lookup per cycle with no backpressure (no ready);
   // out_valid/lut_miss follow exactly two cycles later and are never stalled.

   logic [QUAN_SIZE-1:0] mem [DEPTH];
   logic [ADDR_W-1:0]    rd_addr [LANE_NUM];

   logic [QUAN_SIZE-1:0] rd_s1 [LANE_NUM];
   logic [LANE_NUM-1:0]  tran_s1;
   logic [FRAME_W-1:0]   off_s1;
   logic                 valid_s1;
   logic                 hit_s1;

   logic [BUS_W-1:0]     e_pipe [PIPELINE_DEPTH];

   always_comb begin
      for (int k = 0; k < LANE_NUM; k++) begin
         rd_addr[k] = {read_addr_offset, t00[k*QUAN_SIZE +: QUAN_SIZE], c2v_1[k*QUAN_SIZE +: QUAN_SIZE]};
      end
   end

   // Table contents are deliberately not reset.
   always_ff @(posedge read_clk) begin
      if (lut_we) begin
         mem[{lut_wr_frame, lut_wr_addr}] <= lut_wr_data;
      end
   end

   // Stage 1: synchronous table read; the non-blocking read sees the pre-write contents,
   // so a write landing on the same edge is visible only to the next lookup.
   always_ff @(posedge read_clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < LANE_NUM; k++) rd_s1[k] <= '0;
         tran_s1  <= '0;
         off_s1   <= '0;
         valid_s1 <= 1'b0;
         hit_s1   <= 1'b0;
      end else begin
         for (int k = 0; k < LANE_NUM; k++) rd_s1[k] <= mem[rd_addr[k]];
         tran_s1  <= tran_en_in;
         off_s1   <= read_addr_offset;
         valid_s1 <= in_valid;
         hit_s1   <= frame_loaded[read_addr_offset];
      end
   end

   always_ff @(posedge read_clk or negedge rstn) begin
      if (!rstn) begin
         dn_in                <= '0;
         v2c                  <= '0;
         tran_en_out          <= '0;
         read_addr_offset_out <= '0;
         out_valid            <= 1'b0;
         lut_miss             <= 1'b0;
      end else begin
         for (int k = 0; k < LANE_NUM; k++) begin
            dn_in[k*QUAN_SIZE +: QUAN_SIZE] <= rd_s1[k];
            v2c[k*QUAN_SIZE +: QUAN_SIZE]   <= tran_s1[k] ? ~rd_s1[k] : rd_s1[k];
         end
         tran_en_out          <= tran_s1;
         read_addr_offset_out <= off_s1;
         out_valid            <= valid_s1 & hit_s1;
         lut_miss             <= valid_s1 & ~hit_s1;
      end
   end

   // Commit wins over a same-cycle write to the same frame (write lands, then frame is marked).
   always_ff @(posedge read_clk or negedge rstn) begin
      if (!rstn) begin
         frame_loaded <= '0;
      end else begin
         for (int f = 0; f < MULTI_FRAME_NUM; f++) begin
            if (lut_wr_frame == FRAME_W'(f)) begin
               if (lut_commit)  frame_loaded[f] <= 1'b1;
               else if (lut_we) frame_loaded[f] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge read_clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < PIPELINE_DEPTH; i++) e_pipe[i] <= '0;
      end else begin
         e_pipe[0] <= c2v_2;
         for (int i = 1; i < PIPELINE_DEPTH; i++) e_pipe[i] <= e_pipe[i-1];
      end
   end

   assign e_reg2 = e_pipe[PIPELINE_DEPTH-1];

endmodule

// File: tb/tb_ib_vnu_f1_array.sv
// Bench for ib_vnu_f1_array: directed vector table, hand-written corner sequences and random
// traffic, all checked against a per-frame table model with expected-result queues.
module tb_ib_vnu_f1_array;

   localparam int Q   = 4;
   localparam int LN  = 4;
   localparam int PD  = 3;
   localparam int MFN = 2;
   localparam int FW  = 1;
   localparam int BW  = LN*Q;

   logic          clk;
   logic          rstn;
   logic          in_valid;
   logic [FW-1:0] read_addr_offset;
   logic [BW-1:0] t00, c2v_1, c2v_2;
   logic [LN-1:0] tran_en_in;
   logic          lut_we;
   logic [FW-1:0] lut_wr_frame;
   logic [2*Q-1:0] lut_wr_addr;
   logic [Q-1:0]  lut_wr_data;
   logic          lut_commit;
   logic [BW-1:0] v2c, dn_in, e_reg2;
   logic [LN-1:0] tran_en_out;
   logic [FW-1:0] read_addr_offset_out;
   logic          out_valid, lut_miss;
   logic [MFN-1:0] frame_loaded;

   ib_vnu_f1_array #(.QUAN_SIZE(Q), .LANE_NUM(LN), .PIPELINE_DEPTH(PD), .MULTI_FRAME_NUM(MFN)) dut (
      .read_clk(clk), .rstn(rstn), .in_valid(in_valid), .read_addr_offset(read_addr_offset),
      .t00(t00), .c2v_1(c2v_1), .c2v_2(c2v_2), .tran_en_in(tran_en_in),
      .lut_we(lut_we), .lut_wr_frame(lut_wr_frame), .lut_wr_addr(lut_wr_addr),
      .lut_wr_data(lut_wr_data), .lut_commit(lut_commit),
      .v2c(v2c), .dn_in(dn_in), .e_reg2(e_reg2), .tran_en_out(tran_en_out),
      .read_addr_offset_out(read_addr_offset_out), .out_valid(out_valid),
      .lut_miss(lut_miss), .frame_loaded(frame_loaded)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic vld; logic [FW-1:0] off; logic [BW-1:0] t, c1, c2; logic [LN-1:0] ten;
      logic we; logic [FW-1:0] wf; logic [2*Q-1:0] wa; logic [Q-1:0] wd; logic cm;
   } stim_t;

   typedef struct {
      logic [BW-1:0] dn, v2c; logic [LN-1:0] known, ten; logic [FW-1:0] off; logic ov, miss;
   } exp_t;

   typedef struct {
      stim_t s; logic chk, chk_data; logic [Q-1:0] dn, v2c; logic ten, ov, miss;
   } row_t;

   // Reference model: table contents, which entries hold defined data, and frame load flags.
   logic [Q-1:0] ref_mem   [MFN][256];
   bit           ref_known [MFN][256];
   bit           ref_loaded[MFN];
   exp_t          out_q[$];
   logic [BW-1:0] exp_q[$];

   int n_cmp, n_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic stim_t idle_stim();
      stim_t s;
      s.vld = 1'b0; s.off = '0; s.t = '0; s.c1 = '0; s.c2 = '0; s.ten = '0;
      s.we = 1'b0; s.wf = '0; s.wa = '0; s.wd = '0; s.cm = 1'b0;
      return s;
   endfunction

   function automatic stim_t rd_stim(input logic [FW-1:0] off, input logic [Q-1:0] t,
                                     input logic [Q-1:0] c, input logic ten);
      stim_t s;
      s = idle_stim();
      s.vld = 1'b1; s.off = off; s.t[Q-1:0] = t; s.c1[Q-1:0] = c; s.ten[0] = ten;
      return s;
   endfunction

   function automatic stim_t rand_stim();
      stim_t s;
      s.vld = ($urandom_range(0, 3) != 0);
      s.off = FW'($urandom_range(0, MFN-1));
      s.t = BW'($urandom); s.c1 = BW'($urandom); s.c2 = BW'($urandom); s.ten = LN'($urandom);
      s.we = ($urandom_range(0, 7) == 0);
      s.wf = FW'($urandom_range(0, MFN-1));
      s.wa = 8'($urandom); s.wd = Q'($urandom);
      s.cm = ($urandom_range(0, 15) == 0);
      return s;
   endfunction

   function automatic row_t mk_row(input stim_t s, input logic c, input logic cd, input logic [Q-1:0] dn,
                                   input logic [Q-1:0] v, input logic ten, input logic ov, input logic miss);
      row_t r;
      r.s = s; r.chk = c; r.chk_data = cd; r.dn = dn; r.v2c = v; r.ten = ten; r.ov = ov; r.miss = miss;
      return r;
   endfunction

   task automatic apply(input stim_t s);
      in_valid = s.vld; read_addr_offset = s.off; t00 = s.t; c2v_1 = s.c1; c2v_2 = s.c2;
      tran_en_in = s.ten; lut_we = s.we; lut_wr_frame = s.wf; lut_wr_addr = s.wa;
      lut_wr_data = s.wd; lut_commit = s.cm;
   endtask

   task automatic model_reset();
      exp_t z;
      z.dn = '0; z.v2c = '0; z.known = '1; z.ten = '0; z.off = '0; z.ov = 1'b0; z.miss = 1'b0;
      for (int f = 0; f < MFN; f++) ref_loaded[f] = 1'b0;
      out_q.delete();
      exp_q.delete();
      repeat (2) out_q.push_back(z);
      repeat (PD) exp_q.push_back('0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_v2c"}, v2c, 0);
      chk({tag, "_dn_in"}, dn_in, 0);
      chk({tag, "_e_reg2"}, e_reg2, 0);
      chk({tag, "_tran_en_out"}, tran_en_out, 0);
      chk({tag, "_offset_out"}, read_addr_offset_out, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_lut_miss"}, lut_miss, 0);
      chk({tag, "_frame_loaded"}, frame_loaded, 0);
   endtask

   // Called at a falling edge: check what is due now, drive this cycle, predict, advance.
   task automatic step(input stim_t s);
      exp_t e, r;
      logic [BW-1:0] ee;
      logic [MFN-1:0] fl;
      logic [2*Q-1:0] a;
      logic [Q-1:0] raw;
      e = out_q.pop_front();
      for (int k = 0; k < LN; k++) begin
         if (e.known[k]) begin
            chk($sformatf("dn_in_lane%0d", k), dn_in[k*Q +: Q], e.dn[k*Q +: Q]);
            chk($sformatf("v2c_lane%0d", k), v2c[k*Q +: Q], e.v2c[k*Q +: Q]);
         end
      end
      chk("tran_en_out", tran_en_out, e.ten);
      chk("offset_out", read_addr_offset_out, e.off);
      chk("out_valid", out_valid, e.ov);
      chk("lut_miss", lut_miss, e.miss);
      ee = exp_q.pop_front();
      chk("e_reg2", e_reg2, ee);
      for (int f = 0; f < MFN; f++) fl[f] = ref_loaded[f];
      chk("frame_loaded", frame_loaded, fl);

      apply(s);

      r.off = s.off; r.ten = s.ten;
      r.ov = s.vld && ref_loaded[s.off];
      r.miss = s.vld && !ref_loaded[s.off];
      for (int k = 0; k < LN; k++) begin
         a = {s.t[k*Q +: Q], s.c1[k*Q +: Q]};
         raw = ref_mem[s.off][a];
         r.known[k] = ref_known[s.off][a];
         r.dn[k*Q +: Q] = raw;
         r.v2c[k*Q +: Q] = s.ten[k] ? ~raw : raw;
      end
      out_q.push_back(r);
      exp_q.push_back(s.c2);
      if (s.we) begin
         ref_mem[s.wf][s.wa] = s.wd;
         ref_known[s.wf][s.wa] = 1'b1;
      end
      if (s.cm) ref_loaded[s.wf] = 1'b1;
      else if (s.we) ref_loaded[s.wf] = 1'b0;
      @(negedge clk);
   endtask

   row_t  rows[8];
   stim_t s;

   initial begin
      n_cmp = 0;
      n_err = 0;
      for (int f = 0; f < MFN; f++) for (int i = 0; i < 256; i++) ref_known[f][i] = 1'b0;

      // Clock/reset
      rstn = 1'b0;
      apply(idle_stim());
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rstn = 1'b1;
      model_reset();

      // Load frame 0 with known entries at {3,5} and {4,2}, then commit.
      for (int a = 0; a < 256; a++) begin
         s = idle_stim();
         s.we = 1'b1; s.wf = '0; s.wa = 8'(a);
         s.wd = (a == 8'h35) ? 4'h9 : (a == 8'h42) ? 4'hE : 4'($urandom_range(0, 15));
         step(s);
      end
      s = idle_stim(); s.cm = 1'b1; s.wf = '0;
      step(s);

      // Directed vector table
      rows[0] = mk_row(rd_stim(1'b0, 4'h3, 4'h5, 1'b0), 1, 1, 4'h9, 4'h9, 1'b0, 1'b1, 1'b0);
      rows[1] = mk_row(rd_stim(1'b0, 4'h3, 4'h5, 1'b1), 1, 1, 4'h9, 4'h6, 1'b1, 1'b1, 1'b0);
      rows[2] = mk_row(rd_stim(1'b1, 4'h3, 4'h5, 1'b0), 1, 0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
      s = idle_stim(); s.we = 1'b1; s.wf = 1'b1; s.wa = 8'h35; s.wd = 4'hC;
      rows[3] = mk_row(s, 0, 0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      s = idle_stim(); s.cm = 1'b1; s.wf = 1'b1;
      rows[4] = mk_row(s, 0, 0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      rows[5] = mk_row(rd_stim(1'b1, 4'h3, 4'h5, 1'b0), 1, 1, 4'hC, 4'hC, 1'b0, 1'b1, 1'b0);
      s = idle_stim(); s.we = 1'b1; s.cm = 1'b1; s.wf = 1'b1; s.wa = 8'h11; s.wd = 4'h7;
      rows[6] = mk_row(s, 0, 0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      rows[7] = mk_row(rd_stim(1'b1, 4'h1, 4'h1, 1'b1), 1, 1, 4'h7, 4'h8, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) begin
         step(rows[i].s);
         step(idle_stim());
         if (rows[i].chk) begin
            chk($sformatf("row%0d_out_valid", i), out_valid, rows[i].ov);
            chk($sformatf("row%0d_lut_miss", i), lut_miss, rows[i].miss);
            chk($sformatf("row%0d_tran_en_out", i), tran_en_out[0], rows[i].ten);
            chk($sformatf("row%0d_offset_out", i), read_addr_offset_out, rows[i].s.off);
            if (rows[i].chk_data) begin
               chk($sformatf("row%0d_dn_in", i), dn_in[Q-1:0], rows[i].dn);
               chk($sformatf("row%0d_v2c", i), v2c[Q-1:0], rows[i].v2c);
            end
         end
      end

      // Read-before-write on {4,2} of frame 0, then the write unloads the frame until recommit.
      s = rd_stim(1'b0, 4'h4, 4'h2, 1'b0);
      s.we = 1'b1; s.wf = '0; s.wa = 8'h42; s.wd = 4'h3;
      step(s);
      step(idle_stim());
      chk("rbw_old_data", dn_in[Q-1:0], 4'hE);
      chk("rbw_out_valid", out_valid, 1);
      chk("rbw_frame_cleared", frame_loaded[0], 0);
      step(rd_stim(1'b0, 4'h4, 4'h2, 1'b0));
      step(idle_stim());
      chk("rbw_new_data", dn_in[Q-1:0], 4'h3);
      chk("rbw_unloaded_miss", lut_miss, 1);
      chk("rbw_unloaded_valid", out_valid, 0);
      s = idle_stim(); s.cm = 1'b1; s.wf = '0;
      step(s);
      chk("recommit_frame0", frame_loaded[0], 1);

      // c2v_2 delay line: single pulse must appear exactly PD cycles later, for one cycle.
      s = idle_stim(); s.c2 = 16'h000A;
      step(s);
      step(idle_stim());
      chk("e_reg2_early", e_reg2[Q-1:0], 4'h0);
      step(idle_stim());
      chk("e_reg2_on_time", e_reg2[Q-1:0], 4'hA);
      step(idle_stim());
      chk("e_reg2_after", e_reg2[Q-1:0], 4'h0);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) step(rand_stim());

      // Mid-stream reset with all lanes streaming from frame 0.
      s = idle_stim(); s.cm = 1'b1; s.wf = '0;
      step(s);
      for (int i = 0; i < 8; i++) begin
         s = rand_stim(); s.vld = 1'b1; s.off = '0; s.we = 1'b0; s.cm = 1'b0;
         step(s);
      end
      apply(idle_stim());
      #3 rstn = 1'b0;
      #1 chk_all_zero("midrst");
      @(negedge clk);
      chk_all_zero("midrst_hold");
      rstn = 1'b1;
      model_reset();
      s = rand_stim(); s.vld = 1'b1; s.off = '0; s.we = 1'b0; s.cm = 1'b0;
      step(s);
      step(idle_stim());
      chk("post_rst_out_valid", out_valid, 0);
      chk("post_rst_lut_miss", lut_miss, 1);
      s = idle_stim(); s.cm = 1'b1; s.wf = '0;
      step(s);
      s = rand_stim(); s.vld = 1'b1; s.off = '0; s.we = 1'b0; s.cm = 1'b0;
      step(s);
      step(idle_stim());
      chk("reloaded_out_valid", out_valid, 1);
      for (int i = 0; i < 4; i++) step(idle_stim());

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
